// File: rtl/ps_stage_if.sv
// Packet handshake channel between pipeline stages.
// The sender asserts send with a stable packet; a transfer happens on the
// clock edge where send && ack. W sets the packet width.
interface ps_stage_if #(
  parameter int W = 52
);
  logic         send;
  logic         ack;
  logic [W-1:0] packet;

  modport master (output send, output packet, input ack);
  modport slave  (input send, input packet, output ack);
endinterface

// File: rtl/ps_stage.sv
// Program-storage stage of the data-driven pipeline.
// A matched PS packet (up channel) selects an instruction word in the program
// memory through its dest field. A valid word produces one FP packet
// (dn channel) to dest1. A word with copy=1 produces a second packet to
// dest2, but only when PS_COPY_EN is defined. An invalid word drops the
// packet and bumps a saturating drop counter.
// Signal map: Send_in/Ack_out/PACKET_IN = up.send/up.ack/up.packet,
//             Send_out/Ack_in/PACKET_OUT = dn.send/dn.ack/dn.packet.
// Optional feature macro: PS_COPY_EN (copy nodes, EMIT2 state).
module ps_stage #(
  parameter int PM_DEPTH = 128,
  parameter int PM_WIDTH = 24
) (
  input  logic                CP,
  input  logic                MR_N,
  ps_stage_if.slave           up,
  ps_stage_if.master          dn,
  input  logic                PM_WE,
  input  logic [6:0]          PM_ADDR,
  input  logic [PM_WIDTH-1:0] PM_DATA,
  output logic [7:0]          DROP_CNT
);

  typedef struct packed {
    logic [10:0] tag;
    logic [6:0]  dest;
    logic [1:0]  flags;
    logic [31:0] data;
  } in_pkt_t;

  typedef struct packed {
    logic [10:0] tag;
    logic [5:0]  opcode;
    logic [6:0]  dest;
    logic [31:0] data;
  } out_pkt_t;

  typedef struct packed {
    logic       valid;
    logic       copy;
    logic [6:0] dest2;
    logic [6:0] dest1;
    logic [1:0] rsvd;
    logic [5:0] opcode;
  } instr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
`ifdef PS_COPY_EN
    EMIT1 = 2'd2,
    EMIT2 = 2'd3
`else
    EMIT1 = 2'd2
`endif
  } state_t;

  state_t      state;
  in_pkt_t     pkt_in;
  instr_t      pm [PM_DEPTH];
  instr_t      pm_rd;
  logic [10:0] tag_q;
  logic [6:0]  dest_q;
  logic [31:0] data_q;
  out_pkt_t    out_q;
  logic        send_q;
  logic [7:0]  drop_q;
`ifdef PS_COPY_EN
  logic        copy_q;
  logic [6:0]  dest2_q;
`endif

  assign pkt_in   = in_pkt_t'(up.packet);
  assign pm_rd    = pm[dest_q];
  assign up.ack   = (state == IDLE) && MR_N;
  assign dn.send  = send_q;
  assign dn.packet = out_q;
  assign DROP_CNT = drop_q;

  // Flags and reserved instruction bits are intentionally not forwarded.
  logic unused_bits;
`ifdef PS_COPY_EN
  assign unused_bits = ^{pkt_in.flags, pm_rd.rsvd};
`else
  assign unused_bits = ^{pkt_in.flags, pm_rd.rsvd, pm_rd.copy, pm_rd.dest2};
`endif

  // Program memory write port, independent of the packet FSM.
  // NOTE: the memory array has no reset; clearing it would need a counter
  // sweep, and software loads every word before use anyway.
  always_ff @(posedge CP) begin
    if (PM_WE) pm[PM_ADDR] <= PM_DATA;
  end

  // Packet FSM: accept, fetch instruction, emit one or two FP packets.
  // NOTE: all state here uses <= so a FETCH read on the same edge as a write
  // to that address still sees the old word (read-before-write).
  always_ff @(posedge CP or negedge MR_N) begin
    if (!MR_N) begin
      state  <= IDLE;
      tag_q  <= '0;
      dest_q <= '0;
      data_q <= '0;
      out_q  <= '0;
      send_q <= 1'b0;
      drop_q <= '0;
`ifdef PS_COPY_EN
      copy_q  <= 1'b0;
      dest2_q <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (up.send) begin
            tag_q  <= pkt_in.tag;
            dest_q <= pkt_in.dest;
            data_q <= pkt_in.data;
            state  <= FETCH;
          end
        end
        FETCH: begin
          if (pm_rd.valid) begin
            out_q  <= '{tag: tag_q, opcode: pm_rd.opcode, dest: pm_rd.dest1, data: data_q};
            send_q <= 1'b1;
`ifdef PS_COPY_EN
            copy_q  <= pm_rd.copy;
            dest2_q <= pm_rd.dest2;
`endif
            state  <= EMIT1;
          end else begin
            if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
            state <= IDLE;
          end
        end
        EMIT1: begin
          if (dn.ack) begin
`ifdef PS_COPY_EN
            if (copy_q) begin
              out_q.dest <= dest2_q;
              state      <= EMIT2;
            end else begin
              send_q <= 1'b0;
              state  <= IDLE;
            end
`else
            send_q <= 1'b0;
            state  <= IDLE;
`endif
          end
        end
`ifdef PS_COPY_EN
        EMIT2: begin
          if (dn.ack) begin
            send_q <= 1'b0;
            state  <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps_stage.sv
// Self-checking bench for ps_stage: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// queue-based behavioural model of the stage.
module tb_ps_stage;

`ifdef PS_COPY_EN
  localparam bit COPY_EN = 1'b1;
`else
  localparam bit COPY_EN = 1'b0;
`endif

  logic        CP;
  logic        MR_N;
  logic        PM_WE;
  logic [6:0]  PM_ADDR;
  logic [23:0] PM_DATA;
  logic [7:0]  DROP_CNT;

  ps_stage_if #(.W(52)) up_if ();
  ps_stage_if #(.W(56)) dn_if ();

  ps_stage dut (
    .CP       (CP),
    .MR_N     (MR_N),
    .up       (up_if),
    .dn       (dn_if),
    .PM_WE    (PM_WE),
    .PM_ADDR  (PM_ADDR),
    .PM_DATA  (PM_DATA),
    .DROP_CNT (DROP_CNT)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [23:0] mk_instr(input logic v, input logic c, input logic [6:0] d2,
                                           input logic [6:0] d1, input logic [5:0] op);
    return {v, c, d2, d1, 2'b00, op};
  endfunction

  function automatic logic [55:0] fp(input logic [10:0] tag, input logic [5:0] op,
                                     input logic [6:0] dest, input logic [31:0] data);
    return {tag, op, dest, data};
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  logic [23:0] mem_m [128];
  logic [55:0] exp_q [$];
  logic [55:0] log_q [$];
  bit          fetching = 1'b0;
  logic [51:0] held;
  int          drop_m = 0;

  initial begin
    for (int i = 0; i < 128; i++) mem_m[i] = '0;
    forever begin
      logic [23:0] w;
      @(negedge CP);
      #4;
      if (!MR_N) begin
        check("rst_ack", up_if.ack, 0);
        check("rst_send", dn_if.send, 0);
        check("rst_packet", dn_if.packet, 0);
        check("rst_drop", DROP_CNT, 0);
        exp_q.delete();
        fetching = 1'b0;
        drop_m   = 0;
      end else begin
        check("ack_out", up_if.ack, (!fetching && exp_q.size() == 0));
        check("send_out", dn_if.send, (exp_q.size() != 0));
        if (exp_q.size() != 0) check("packet_out", dn_if.packet, exp_q[0]);
        check("drop_cnt", DROP_CNT, drop_m);
        if (dn_if.send && dn_if.ack) log_q.push_back(dn_if.packet);
        // Advance the model across the coming edge.
        if (!fetching && exp_q.size() == 0 && up_if.send) begin
          fetching = 1'b1;
          held     = up_if.packet;
        end else if (fetching) begin
          fetching = 1'b0;
          w = mem_m[held[40:34]];
          if (w[23]) begin
            exp_q.push_back(fp(held[51:41], w[5:0], w[14:8], held[31:0]));
            if (COPY_EN && w[22]) exp_q.push_back(fp(held[51:41], w[5:0], w[21:15], held[31:0]));
          end else if (drop_m < 255) begin
            drop_m++;
          end
        end else if (exp_q.size() != 0 && dn_if.ack) begin
          void'(exp_q.pop_front());
        end
      end
      // Memory writes land after this edge's fetch read.
      if (PM_WE) mem_m[PM_ADDR] = PM_DATA;
    end
  end

  // ---------------- driver helpers (entered and left at a negedge) ----------------
  task automatic pm_write(input logic [6:0] addr, input logic [23:0] data);
    PM_WE = 1'b1;
    PM_ADDR = addr;
    PM_DATA = data;
    @(negedge CP);
    PM_WE = 1'b0;
  endtask

  task automatic send_pkt(input logic [6:0] dest, input logic [10:0] tag, input logic [31:0] data);
    int n = 0;
    while (!up_if.ack && n < 50) begin
      @(negedge CP);
      n++;
    end
    check("ready_wait", up_if.ack, 1);
    up_if.send   = 1'b1;
    up_if.packet = {tag, dest, 2'($urandom_range(0, 3)), data};
    @(negedge CP);
    up_if.send = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge CP);
      n++;
    end while (!up_if.ack && n < 50);
    check("idle_wait", up_if.ack, 1);
  endtask

  task automatic wait_send();
    int n = 0;
    while (!dn_if.send && n < 50) begin
      @(negedge CP);
      n++;
    end
    check("send_wait", dn_if.send, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int base;
    MR_N = 1'b1;
    PM_WE = 1'b0;
    PM_ADDR = '0;
    PM_DATA = '0;
    up_if.send = 1'b0;
    up_if.packet = '0;
    dn_if.ack = 1'b1;
    #1 MR_N = 1'b0;
    repeat (3) @(negedge CP);
    MR_N = 1'b1;
    #1 check("ack_after_reset", up_if.ack, 1);

    // Clear program memory so every word starts invalid.
    for (int a = 0; a < 128; a++) pm_write(7'(a), 24'h0);

    // Single packet, non-copy node.
    pm_write(7'd5, mk_instr(1'b1, 1'b0, 7'h00, 7'h12, 6'h03));
    send_pkt(7'd5, 11'h2A5, 32'h1234ABCD);
    check("t1_fetch_no_send", dn_if.send, 0);
    check("t1_fetch_busy", up_if.ack, 0);
    @(negedge CP);
    check("t1_send", dn_if.send, 1);
    check("t1_packet", dn_if.packet, fp(11'h2A5, 6'h03, 7'h12, 32'h1234ABCD));
    @(negedge CP);
    check("t1_done_send", dn_if.send, 0);
    check("t1_done_ack", up_if.ack, 1);

    // Copy node.
    pm_write(7'd9, mk_instr(1'b1, 1'b1, 7'h21, 7'h20, 6'h0A));
    base = log_q.size();
    send_pkt(7'd9, 11'h155, 32'hCAFEF00D);
    wait_idle();
    check("copy_count", log_q.size() - base, COPY_EN ? 2 : 1);
    check("copy_first", log_q[base], fp(11'h155, 6'h0A, 7'h20, 32'hCAFEF00D));
    check("copy_last", log_q[log_q.size() - 1],
          fp(11'h155, 6'h0A, COPY_EN ? 7'h21 : 7'h20, 32'hCAFEF00D));

    // Single drop on an invalid word.
    send_pkt(7'h7F, 11'h001, 32'h0);
    check("drop_busy", up_if.ack, 0);
    @(negedge CP);
    check("drop_ready", up_if.ack, 1);
    check("drop_cnt_one", DROP_CNT, 1);
    check("drop_no_send", dn_if.send, 0);

    // Back-pressure: Ack_in low for 10 cycles during EMIT1.
    dn_if.ack = 1'b0;
    send_pkt(7'd5, 11'h011, 32'hDEADBEEF);
    wait_send();
    for (int i = 0; i < 10; i++) begin
      check("bp_send", dn_if.send, 1);
      check("bp_packet", dn_if.packet, fp(11'h011, 6'h03, 7'h12, 32'hDEADBEEF));
      check("bp_ack_out", up_if.ack, 0);
      @(negedge CP);
    end
    dn_if.ack = 1'b1;
    @(negedge CP);
    check("bp_release_send", dn_if.send, 0);
    check("bp_release_ack", up_if.ack, 1);

    // Write/read collision on address 5.
    send_pkt(7'd5, 11'h3C3, 32'h0BADCAFE);
    PM_WE = 1'b1;
    PM_ADDR = 7'd5;
    PM_DATA = mk_instr(1'b1, 1'b0, 7'h00, 7'h33, 6'h03);
    @(negedge CP);
    PM_WE = 1'b0;
    check("coll_old_word", dn_if.packet, fp(11'h3C3, 6'h03, 7'h12, 32'h0BADCAFE));
    wait_idle();
    send_pkt(7'd5, 11'h3C4, 32'h00000001);
    wait_send();
    check("coll_new_word", dn_if.packet, fp(11'h3C4, 6'h03, 7'h33, 32'h00000001));
    wait_idle();

    // Randomized phase: random program, traffic, back-pressure and writes.
    for (int a = 0; a < 128; a++) begin
      logic [31:0] r;
      r = $urandom;
      pm_write(7'(a), mk_instr(r[0] | r[1], r[2], r[9:3], r[16:10], r[22:17]));
    end
    for (int c = 0; c < 2000; c++) begin
      logic [63:0] rp;
      logic [31:0] r;
      rp = {$urandom, $urandom};
      r  = $urandom;
      dn_if.ack    = ($urandom_range(0, 3) != 0);
      up_if.send   = ($urandom_range(0, 1) != 0);
      up_if.packet = rp[51:0];
      PM_WE   = ($urandom_range(0, 15) == 0);
      PM_ADDR = r[29:23];
      PM_DATA = mk_instr(r[0] | r[1], r[2], r[9:3], r[16:10], r[22:17]);
      @(negedge CP);
    end
    up_if.send = 1'b0;
    PM_WE = 1'b0;
    dn_if.ack = 1'b1;
    wait_idle();

    // Saturation: 300 drops.
    pm_write(7'h7F, 24'h0);
    for (int i = 0; i < 300; i++) send_pkt(7'h7F, 11'(i), $urandom);
    wait_idle();
    check("drop_saturated", DROP_CNT, 255);

    // Reset during EMIT1.
    pm_write(7'd5, mk_instr(1'b1, 1'b0, 7'h00, 7'h12, 6'h03));
    dn_if.ack = 1'b0;
    base = log_q.size();
    send_pkt(7'd5, 11'h777, 32'h55AA55AA);
    wait_send();
    #1 MR_N = 1'b0;
    #1;
    check("mid_rst_send", dn_if.send, 0);
    check("mid_rst_packet", dn_if.packet, 0);
    check("mid_rst_drop", DROP_CNT, 0);
    check("mid_rst_ack", up_if.ack, 0);
    @(negedge CP);
    MR_N = 1'b1;
    dn_if.ack = 1'b1;
    #1 check("post_rst_ack", up_if.ack, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge CP);
      check("post_rst_no_send", dn_if.send, 0);
    end
    check("no_stale_transfer", log_q.size() - base, 0);

    @(negedge CP);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
